// File: rtl/dff_pipe.sv
// Parametrised WIDTH x DEPTH register pipeline with per-stage valid, advance enable,
// synchronous flush and reset value. Define DFF_PIPE_COUNT_EN to build the occupancy counter.
module dff_pipe #(
   parameter int unsigned             WIDTH       = 8,
   parameter int unsigned             DEPTH       = 4,
   parameter logic [WIDTH-1:0]        RESET_VALUE = '0,
   localparam int unsigned            CW          = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             flush,
   input  logic [WIDTH-1:0] d,
   input  logic             d_valid,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] vld_d;

   // Bubbles advance with the data; flush wins over en.
   always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) data_d[i] = RESET_VALUE;
         vld_d = '0;
      end else if (en) begin
         data_d[0] = d;
         vld_d[0]  = d_valid;
         for (int i = 1; i < DEPTH; i++) begin
            data_d[i] = data_q[i-1];
            vld_d[i]  = vld_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VALUE;
         vld_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
         vld_q <= vld_d;
      end
   end

   assign q       = data_q[DEPTH-1];
   assign q_valid = vld_q[DEPTH-1];

`ifdef DFF_PIPE_COUNT_EN
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Tracks popcount(vld): one in at stage 0, one out past the last stage.
   always_comb begin
      cnt_d = cnt_q;
      if (flush) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CW'(d_valid) - CW'(vld_q[DEPTH-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign count = cnt_q;
`else
   assign count = '0;
`endif

endmodule

// File: doc/dff_pipe.md
# dff_pipe

Parametrised D-flip-flop pipeline: a WIDTH-bit × DEPTH-stage register chain with per-stage valid tracking, a global advance enable, a synchronous flush and a programmable reset value. It generalises the single-bit DFF into the delay/retiming element the datapath uses wherever a signal must be delayed a fixed number of cycles with bubbles and stalls. It sits between producer and consumer blocks on the single system clock domain.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1); DEPTH=1 behaves as a DFF with valid
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into every data stage on reset and flush
- CW, $clog2(DEPTH+1), width of `count` (derived, not overridden)

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  advance: 1 = shift chain one stage, 0 = hold all stages
- flush  input  1  synchronous clear of all stages (data and valid)
- d  input  WIDTH  data into stage 0
- d_valid  input  1  qualifies `d`
- q  output  WIDTH  data of stage DEPTH-1
- q_valid  output  1  valid of stage DEPTH-1
- count  output  CW  number of stages currently holding valid data

## Operation
- Registers: data[0..DEPTH-1] (WIDTH bits each), vld[0..DEPTH-1], cnt (CW bits).
- Priority per rising edge: reset > flush > en > hold.
- reset=1: all data[i] ← RESET_VALUE, all vld[i] ← 0, cnt ← 0.
- flush=1 (reset=0): same as reset; `d`/`d_valid` that cycle discarded regardless of `en`.
- en=1 (reset=0, flush=0): data[0] ← d, vld[0] ← d_valid; data[i] ← data[i-1], vld[i] ← vld[i-1] for i≥1. Data moves even when its valid is 0 (bubble advances).
- en=0: all registers hold; d/d_valid ignored.
- Counter (when compiled in): on en shift, cnt ← cnt + d_valid − vld[DEPTH-1]; simultaneous in/out leaves cnt unchanged; no wrap possible since 0 ≤ cnt ≤ DEPTH always. Invariant: cnt == popcount(vld) every cycle.
- q = data[DEPTH-1], q_valid = vld[DEPTH-1], count = cnt; all outputs registered, no combinational path from inputs.

## Timing
- Reset values: q = RESET_VALUE, q_valid = 0, count = 0, visible the cycle after reset sampled high.
- Latency: value presented at edge k with en=1 held appears on q after edge k+DEPTH-1 (i.e., valid on q during cycle k+DEPTH, DEPTH enabled edges total).
- Stall: each edge with en=0 adds exactly one cycle of latency; no data lost or duplicated.
- Throughput: one word per cycle with en=1 continuous.
- Reset or flush mid-stream: all in-flight words lost; first new word after deassert follows normal latency.
- reset/flush deasserted and en=1 on same edge: that edge still clears (priority).

## Configuration
- Macro DFF_PIPE_COUNT_EN.
- Defined: cnt register and update logic built; `count` reports occupancy as above.
- Undefined: no counter logic; `count` tied to 0; port list unchanged so instantiations are identical in both builds.

## Test plan
- Reset: WIDTH=8, DEPTH=4, RESET_VALUE=8'hA5, reset=1 for 2 cycles → q=8'hA5, q_valid=0, count=0.
- Streaming: en=1, d=8'h01,02,03,04,05 with d_valid=1 on consecutive edges → q=8'h01 with q_valid=1 after 4th edge, then 02..05 on following cycles; count ramps 1,2,3,4 and holds 4.
- Stall: load 8'h11 then en=0 for 3 cycles → q/q_valid/count frozen; resume en=1 → 8'h11 emerges exactly 3 cycles later than unstalled.
- Bubbles: d_valid pattern 1,0,1,0 with d=8'h10..13 → q_valid pattern 1,0,1,0 DEPTH edges later; count never exceeds 2.
- Flush mid-stream: 3 valid words in flight, flush=1 with en=1, d_valid=1 → next cycle all vld=0, q=RESET_VALUE, count=0; the word presented with flush never appears.
- Macro off: repeat streaming test without DFF_PIPE_COUNT_EN → q/q_valid identical, count constantly 0.
